// File: rtl/hamming_secded_pkg.sv
// Shared definitions for the SECDED(16,11) checker: code layout, syndrome,
// parity, payload extraction and an encoder for building test words.
`timescale 1ns/1ps
package hamming_secded_pkg;

  localparam int unsigned CODE_W = 16;
  localparam int unsigned PAYLOAD_W = 11;

  typedef enum logic [1:0] {CLEAN, SINGLE, PARITY_ONLY, DOUBLE} err_class_e;

  // Code position of payload bit d[j]; check bits sit at 1, 2, 4, 8 and parity at 0.
  localparam logic [3:0] DATA_POS [PAYLOAD_W] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10,
                                                  4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  function automatic logic [3:0] syndrome(input logic [CODE_W-1:0] c);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (c[i]) s = s ^ i[3:0];
    end
    return s;
  endfunction

  function automatic logic parity(input logic [CODE_W-1:0] c);
    return ^c;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [PAYLOAD_W-1:0] d;
    d = '0;
    for (int j = 0; j < PAYLOAD_W; j++) d[j] = c[DATA_POS[j]];
    return d;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [PAYLOAD_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic [3:0] s;
    c = '0;
    for (int j = 0; j < PAYLOAD_W; j++) c[DATA_POS[j]] = d[j];
    // Check bits at power-of-two positions cancel the data-only syndrome.
    s = syndrome(c);
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c;
    return c;
  endfunction

endpackage

// File: rtl/hamming_secded_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
`timescale 1ns/1ps
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hamming_secded_checker.sv
// Extended Hamming SECDED(16,11) checker with a 2-stage pipeline and
// saturating error statistics. Optional error injection on the capture path
// is enabled by defining HAMMING_SECDED_INJECT_EN.
`timescale 1ns/1ps
module hamming_secded_checker
  import hamming_secded_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [15:0]       code_in,
`ifdef HAMMING_SECDED_INJECT_EN
  input  logic [15:0]       inj_mask,
  input  logic              inj_en,
`endif
  input  logic              stat_clr,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              err_single,
  output logic              err_double,
  output logic [3:0]        err_pos,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic [CODE_W-1:0] code_cap;
  logic [CODE_W-1:0] code_q;
  logic [3:0]        syn_q;
  logic              par_q;
  logic              v1_q;

  logic              v2_q;
  logic [DATA_W-1:0] data_q;
  logic              es_q, ed_q;
  logic [3:0]        pos_q;

  err_class_e        cls;
  logic [CODE_W-1:0] fixed_code;

`ifdef HAMMING_SECDED_INJECT_EN
  assign code_cap = inj_en ? (code_in ^ inj_mask) : code_in;
`else
  assign code_cap = code_in;
`endif

  // Stage 1: capture word, syndrome and overall parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
      syn_q  <= '0;
      par_q  <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      code_q <= code_cap;
      syn_q  <= syndrome(code_cap);
      par_q  <= parity(code_cap);
      v1_q   <= code_valid;
    end
  end

  // Classify the stage-1 word and build the corrected code word.
  always_comb begin
    cls        = CLEAN;
    fixed_code = code_q;
    if (par_q) begin
      if (syn_q != 4'd0) begin
        cls        = SINGLE;
        fixed_code = code_q ^ (16'(1) << syn_q);
      end else begin
        cls = PARITY_ONLY;
      end
    end else if (syn_q != 4'd0) begin
      cls = DOUBLE;
    end
  end

  // Stage 2: payload and position hold when idle; flags only on valid words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q   <= 1'b0;
      data_q <= '0;
      es_q   <= 1'b0;
      ed_q   <= 1'b0;
      pos_q  <= '0;
    end else begin
      v2_q <= v1_q;
      es_q <= 1'b0;
      ed_q <= 1'b0;
      if (v1_q) begin
        data_q <= extract(fixed_code);
        pos_q  <= syn_q;
        unique case (cls)
          SINGLE, PARITY_ONLY: es_q <= 1'b1;
          DOUBLE:              ed_q <= 1'b1;
          default:             ;
        endcase
      end
    end
  end

  assign data_valid = v2_q;
  assign data_out   = data_q;
  assign err_single = es_q;
  assign err_double = ed_q;
  assign err_pos    = pos_q;

  sat_counter #(.CNT_W(CNT_W)) u_corr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (v2_q & es_q),
    .clr (stat_clr),
    .cnt (corr_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_uncorr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (v2_q & ed_q),
    .clr (stat_clr),
    .cnt (uncorr_cnt)
  );

endmodule

// File: tb/tb_hamming_secded_checker.sv
// Directed bench for hamming_secded_checker with CNT_W=2 so saturation is reachable.
`timescale 1ns/1ps
module tb_hamming_secded_checker;
  import hamming_secded_pkg::*;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          code_valid;
  logic [15:0]   code_in;
  logic          stat_clr;
  logic          data_valid;
  logic [10:0]   data_out;
  logic          err_single;
  logic          err_double;
  logic [3:0]    err_pos;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  int total = 0;
  int bad   = 0;

  hamming_secded_checker #(.CNT_W(CW), .DATA_W(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_in    (code_in),
    .stat_clr   (stat_clr),
    .data_valid (data_valid),
    .data_out   (data_out),
    .err_single (err_single),
    .err_double (err_double),
    .err_pos    (err_pos),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs seen right after
  // reflect the word applied two calls earlier.
  task automatic apply(input logic v, input logic [15:0] c, input logic clr);
    @(negedge clk);
    code_valid = v;
    code_in    = c;
    stat_clr   = clr;
  endtask

  logic pat [26];

  initial begin
    rst = 1'b1; code_valid = 1'b0; code_in = '0; stat_clr = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_dv", 16'(data_valid), 16'h0);
    chk("rst_data", 16'(data_out), 16'h0);
    chk("rst_pos", 16'(err_pos), 16'h0);
    chk("rst_flags", {14'h0, err_single, err_double}, 16'h0);
    chk("rst_cnt", {12'h0, corr_cnt, uncorr_cnt}, 16'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Clean, single, parity-only and double error words back to back.
    apply(1'b1, 16'h0000, 1'b0);
    apply(1'b1, 16'h000F, 1'b0);
    apply(1'b1, 16'h002F, 1'b0);
    chk("clean0_dv", 16'(data_valid), 16'h1);
    chk("clean0_data", 16'(data_out), 16'h000);
    chk("clean0_flags", {14'h0, err_single, err_double}, 16'h0);
    apply(1'b1, 16'h000E, 1'b0);
    chk("clean1_data", 16'(data_out), 16'h001);
    chk("clean1_flags", {14'h0, err_single, err_double}, 16'h0);
    chk("clean1_cnt", {12'h0, corr_cnt, uncorr_cnt}, 16'h0);
    apply(1'b1, 16'h006F, 1'b0);
    chk("single_data", 16'(data_out), 16'h001);
    chk("single_es", 16'(err_single), 16'h1);
    chk("single_ed", 16'(err_double), 16'h0);
    chk("single_pos", 16'(err_pos), 16'h5);
    apply(1'b0, 16'h0000, 1'b0);
    chk("single_corr", 16'(corr_cnt), 16'h1);
    chk("par_data", 16'(data_out), 16'h001);
    chk("par_es", 16'(err_single), 16'h1);
    chk("par_pos", 16'(err_pos), 16'h0);
    apply(1'b0, 16'h0000, 1'b0);
    chk("par_corr", 16'(corr_cnt), 16'h2);
    chk("dbl_ed", 16'(err_double), 16'h1);
    chk("dbl_es", 16'(err_single), 16'h0);
    chk("dbl_pos", 16'(err_pos), 16'h3);
    chk("dbl_data", 16'(data_out), 16'h007);
    apply(1'b0, 16'h0000, 1'b0);
    chk("idle_dv", 16'(data_valid), 16'h0);
    chk("idle_flags", {14'h0, err_single, err_double}, 16'h0);
    chk("idle_hold_data", 16'(data_out), 16'h007);
    chk("idle_hold_pos", 16'(err_pos), 16'h3);
    chk("dbl_uncorr", 16'(uncorr_cnt), 16'h1);
    chk("dbl_corr_keep", 16'(corr_cnt), 16'h2);

    // Saturation: five more single errors take corr_cnt from 2 to its max of 3.
    for (int i = 0; i < 5; i++) apply(1'b1, 16'h002F, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 16'h0000, 1'b0);
    chk("sat_corr", 16'(corr_cnt), 16'h3);

    // Clear coincident with an increment: clear wins.
    apply(1'b1, 16'h002F, 1'b0);
    apply(1'b0, 16'h0000, 1'b0);
    apply(1'b0, 16'h0000, 1'b1);
    chk("clr_coinc_dv", 16'(data_valid), 16'h1);
    chk("clr_coinc_es", 16'(err_single), 16'h1);
    apply(1'b0, 16'h0000, 1'b0);
    chk("clr_corr", 16'(corr_cnt), 16'h0);
    chk("clr_uncorr", 16'(uncorr_cnt), 16'h0);

    // Gap: 10 high, 9 low, 5 high, then idle; data_valid follows 2 cycles later.
    for (int i = 0; i < 26; i++) pat[i] = (i < 10) || (i >= 19 && i < 24);
    for (int i = 0; i < 26; i++) begin
      apply(pat[i], encode(11'(i + 1)), 1'b0);
      if (i >= 2) begin
        chk($sformatf("gap_dv_%0d", i - 2), 16'(data_valid), 16'(pat[i-2]));
        if (pat[i-2]) chk($sformatf("gap_data_%0d", i - 2), 16'(data_out), 16'(i - 1));
      end
    end
    chk("gap_tail_data", 16'(data_out), 16'd24);

    // Reset mid-stream with words in flight.
    for (int i = 0; i < 4; i++) apply(1'b1, 16'h002F, 1'b0);
    chk("pre_rst_corr", 16'(corr_cnt), 16'h1);
    chk("pre_rst_dv", 16'(data_valid), 16'h1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_dv", 16'(data_valid), 16'h0);
    chk("mid_rst_data", 16'(data_out), 16'h0);
    chk("mid_rst_flags", {14'h0, err_single, err_double}, 16'h0);
    chk("mid_rst_pos", 16'(err_pos), 16'h0);
    chk("mid_rst_corr", 16'(corr_cnt), 16'h0);
    code_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 16'h0000, 1'b0);
      chk($sformatf("post_rst_dv_%0d", i), 16'(data_valid), 16'h0);
    end
    apply(1'b1, 16'h000F, 1'b0);
    apply(1'b0, 16'h0000, 1'b0);
    chk("first_lat1_dv", 16'(data_valid), 16'h0);
    apply(1'b0, 16'h0000, 1'b0);
    chk("first_dv", 16'(data_valid), 16'h1);
    chk("first_data", 16'(data_out), 16'h001);
    apply(1'b0, 16'h0000, 1'b0);
    chk("first_after_dv", 16'(data_valid), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_secded_checker.md
Name: hamming_secded_checker

Overview:
- Downstream consumer of the 16-bit counter/code-word stage.
- Treats each incoming 16-bit word as an extended Hamming SECDED(16,11) code word, corrects single-bit errors and flags double-bit errors.
- Delivers the 11-bit payload with a 2-stage registered pipeline.
- Keeps saturating statistics of corrected and uncorrectable words for the status/readout logic.

Parameters:
- CNT_W, 8, width of each error-statistics counter.
- DATA_W, 11, payload width; fixed by the code, for documentation and checking only; must be 11.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- code_valid  in  1  qualifies code_in; driven by the upstream enable.
- code_in  in  16  received code word (upstream counter value).
- stat_clr  in  1  synchronous clear of both statistics counters.
- data_valid  out  1  data_out/err flags valid this cycle.
- data_out  out  11  corrected payload.
- err_single  out  1  single error detected and corrected (incl. bit 0).
- err_double  out  1  uncorrectable double error.
- err_pos  out  4  syndrome / corrected bit position; 0 = bit 0 or no error.
- corr_cnt  out  CNT_W  count of words with err_single.
- uncorr_cnt  out  CNT_W  count of words with err_double.

Behaviour:
- Code layout:
  - bit 0 = overall parity (even over all 16 bits).
  - bits 1, 2, 4, 8 = Hamming check bits.
  - Data bits d[0..10] sit at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, in ascending order.
- Stage 1, registered:
  - Capture code_in and the 4-bit syndrome s = XOR of indices i (1..15) where code_in[i]=1.
  - Capture overall parity P = XOR of all 16 bits.
  - v1 <= code_valid.
- Stage 2, registered, classifies the word:
  - s=0, P=0: clean. Both err flags 0.
  - s≠0, P=1: single error. Flip bit s, err_single=1, err_pos=s.
  - s=0, P=1: single error in parity bit 0. Data unchanged, err_single=1, err_pos=0.
  - s≠0, P=0: double error. Data extracted uncorrected, err_double=1, err_pos=s.
- Latency: exactly 2 clk from code_valid=1 to data_valid=1. Full throughput, one word per cycle, no backpressure.
- When data_valid=0, err_single and err_double are forced 0. data_out and err_pos hold their last value.
- Counters:
  - corr_cnt increments on data_valid & err_single; uncorr_cnt increments on data_valid & err_double.
  - Both saturate at 2^CNT_W-1; no wrap.
  - stat_clr=1 zeroes both next cycle. If a clear coincides with an increment, the clear wins (result 0).
  - Pipeline contents are unaffected by stat_clr.
- Reset:
  - All outputs, pipeline registers and valid bits go to 0 immediately on rst=0.
  - Reset asserted mid-stream drops in-flight words; no data_valid pulse for them after release.
  - First valid output appears 2 cycles after the first code_valid following release.
- A code_valid gap (upstream enable low) produces a matching gap in data_valid, delayed by 2 cycles.

Optional Feature:
- Macro: HAMMING_SECDED_INJECT_EN.
- Defined:
  - Adds input inj_mask[15:0] and input inj_en.
  - When inj_en=1, stage 1 captures code_in ^ inj_mask instead of code_in.
  - Used for on-silicon self-test of the correction path.
- Undefined: ports absent, code_in is captured directly, no extra logic.

Decomposition:
- Package hamming_secded_pkg holds:
  - the position-map constant (data index to code position);
  - the syndrome and parity functions;
  - the encode function used by benches;
  - localparam CODE_W=16.
- Error-class enum: CLEAN, SINGLE, PARITY_ONLY, DOUBLE.
- One sub-module is natural: sat_counter, instantiated twice (inc, clr, saturating, CNT_W).

Test Plan:
- Clean words: code_valid=1, code_in=16'h0000 then 16'h000F (payload 11'h001) -> two cycles later, data_out=11'h000 then 11'h001, both err flags 0, counters stay 0.
- Single error: code_in=16'h002F (bit 5 flipped on 16'h000F) -> data_out=11'h001, err_single=1, err_pos=5, corr_cnt=1.
- Parity-bit error: code_in=16'h000E -> data_out=11'h001, err_single=1, err_pos=0, corr_cnt increments.
- Double error: code_in=16'h006F (bits 5 and 6 flipped) -> err_double=1, err_pos=3, uncorr_cnt=1, err_single=0.
- Saturation and clear, with CNT_W=2:
  - 5 consecutive single-error words -> corr_cnt holds at 3.
  - stat_clr asserted together with a single-error word -> corr_cnt=0.
- Gap and reset:
  - Enable pattern 10 high, 9 low, 5 high -> data_valid shows the same pattern shifted by 2 cycles.
  - rst=0 asserted while 2 words are in flight -> outputs 0 at once; no data_valid after release until new input.
